fir_l3_input_demux: RTL and testbench

Serial-to-parallel input stage for the three-parallel (L=3) reduced-complexity FIR. Accepts one signed sample per handshake and assembles L consecutive samples into one block. The block is presented to the parallel filter core as a registered, valid-qualified word. The stage absorbs backpressure from the core and supports a flush that zero-pads a partial block at end of stream.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_l3_input_demux.sv | 103 ++++++++++
 tb/tb_fir_l3_input_demux.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the L-parallel reduced-complexity FIR.
package fir_pkg;
  localparam int FIR_DATA_IN_WIDTH = 16;
  localparam int FIR_PARALLEL_L    = 3;

  typedef logic signed [FIR_DATA_IN_WIDTH-1:0]                 fir_sample_t;
  typedef logic        [FIR_PARALLEL_L-1:0][FIR_DATA_IN_WIDTH-1:0] fir_block_t;

  typedef enum logic {
    COLLECT    = 1'b0,
    FLUSH_WAIT = 1'b1
  } demux_st_e;
endpackage

// File: rtl/fir_l3_input_demux.sv
// Serial-to-parallel input stage: packs L consecutive samples into one
// registered, valid-qualified block; flush zero-pads a partial block.
module fir_l3_input_demux
  import fir_pkg::*;
#(
  parameter int DATA_IN_WIDTH = FIR_DATA_IN_WIDTH,
  parameter int L             = FIR_PARALLEL_L,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_IN_WIDTH-1:0]   s_data,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [L*DATA_IN_WIDTH-1:0] m_data,
  output logic [$clog2(L+1)-1:0]     m_pad,
  output logic [COUNT_WIDTH-1:0]     block_count
);
  localparam int W  = DATA_IN_WIDTH;
  localparam int IW = $clog2(L);
  localparam int PW = $clog2(L+1);

  demux_st_e            st_q, st_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [L-2:0][W-1:0]  buf_q, buf_d;
  logic [L-1:0][W-1:0]  blk_d;
  logic [PW-1:0]        pad_d;
  logic                 last_lane, out_free, acc, complete, commit, load;

  assign last_lane = (idx_q == IW'(L-1));
  assign out_free  = !m_valid || m_ready;
  // Only the completing sample needs the output register; m_ready feeds s_ready directly.
  assign s_ready   = (st_q == COLLECT) && (!last_lane || out_free);
  assign acc       = s_valid && s_ready;
  assign complete  = acc && last_lane;

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    buf_d  = buf_q;
    commit = 1'b0;
    if (acc) begin
      idx_d = last_lane ? '0 : idx_q + 1'b1;
      for (int k = 0; k < L-1; k++)
        if (idx_q == IW'(k)) buf_d[k] = s_data;
    end
    // A same-cycle sample is already folded into idx_d/buf_d before flush looks at it.
    case (st_q)
      COLLECT: begin
        if (flush && idx_d != '0) begin
          if (out_free) commit = 1'b1;
          else          st_d   = FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: begin
        if (out_free) begin
          commit = 1'b1;
          st_d   = COLLECT;
        end
      end
      default: st_d = COLLECT;
    endcase
    for (int k = 0; k < L-1; k++)
      blk_d[k] = (complete || IW'(k) < idx_d) ? buf_d[k] : '0;
    blk_d[L-1] = complete ? s_data : '0;
    pad_d      = complete ? '0 : PW'(L) - PW'(idx_d);
    load       = complete || commit;
    if (commit) idx_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= COLLECT;
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_pad       <= '0;
      block_count <= '0;
    end else begin
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= blk_d;
        m_pad   <= pad_d;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready) block_count <= block_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_l3_input_demux.sv
// Table-driven bench for fir_l3_input_demux with an expected-block scoreboard.
module tb_fir_l3_input_demux;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid, s_ready, flush, m_valid, m_ready;
  logic [15:0] s_data;
  logic [47:0] m_data;
  logic [1:0]  m_pad;
  logic [15:0] block_count;

  fir_l3_input_demux dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_pad(m_pad), .block_count(block_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        fl;
    logic        mr;
    logic        rdy;
    logic        mv;
    int          cnt;
    logic        push;
    logic [47:0] blk;
    logic [1:0]  pad;
  } vec_t;

  typedef struct {
    logic [47:0] blk;
    logic [1:0]  pad;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t v(input bit sv, input int sd, input bit fl, input bit mr,
                             input bit rdy, input bit mv, input int cnt);
    vec_t t;
    t.sv = sv; t.sd = 16'(sd); t.fl = fl; t.mr = mr; t.rdy = rdy; t.mv = mv;
    t.cnt = cnt; t.push = 1'b0; t.blk = '0; t.pad = '0;
    return t;
  endfunction

  function automatic vec_t vp(input vec_t b, input logic [47:0] blk, input logic [1:0] pad);
    vec_t t = b;
    t.push = 1'b1; t.blk = blk; t.pad = pad;
    return t;
  endfunction

  function automatic logic [47:0] blk3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    s_valid = t.sv; s_data = t.sd; flush = t.fl; m_ready = t.mr;
    #1;
    chk("s_ready", s_ready, t.rdy);
    chk("m_valid", m_valid, t.mv);
    if (t.cnt >= 0) chk("block_count", block_count, t.cnt);
    if (t.push) sb.push_back('{t.blk, t.pad});
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL handoff: got unexpected block %0h expected none", m_data);
      end else begin
        e = sb.pop_front();
        chk("m_data", m_data, e.blk);
        chk("m_pad", m_pad, e.pad);
      end
    end
    @(posedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_pad", m_pad, 0);
    chk("rst_block_count", block_count, 0);
    chk("rst_s_ready", s_ready, 1);
  endtask

  initial begin
    // full blocks at full rate
    vecs.push_back(v(1, 1, 0, 1, 1, 0, -1));
    vecs.push_back(v(1, 2, 0, 1, 1, 0, -1));
    vecs.push_back(vp(v(1, 3, 0, 1, 1, 0, -1), blk3(1, 2, 3), 0));
    vecs.push_back(v(1, 4, 0, 1, 1, 1, -1));
    vecs.push_back(v(1, 5, 0, 1, 1, 0, -1));
    vecs.push_back(vp(v(1, 6, 0, 1, 1, 0, -1), blk3(4, 5, 6), 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 2));
    // backpressure: completing sample waits for the drain
    vecs.push_back(v(1, 20, 0, 0, 1, 0, -1));
    vecs.push_back(v(1, 21, 0, 0, 1, 0, -1));
    vecs.push_back(vp(v(1, 22, 0, 0, 1, 0, -1), blk3(20, 21, 22), 0));
    vecs.push_back(v(1, 7, 0, 0, 1, 1, -1));
    vecs.push_back(v(1, 8, 0, 0, 1, 1, -1));
    vecs.push_back(v(1, 9, 0, 0, 0, 1, -1));
    vecs.push_back(v(1, 9, 0, 0, 0, 1, -1));
    vecs.push_back(vp(v(1, 9, 0, 1, 1, 1, -1), blk3(7, 8, 9), 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 4));
    // flush of a partial block, then flush at idx 0 is a no-op
    vecs.push_back(v(1, 10, 0, 1, 1, 0, -1));
    vecs.push_back(v(1, 11, 0, 1, 1, 0, -1));
    vecs.push_back(vp(v(0, 0, 1, 1, 1, 0, -1), blk3(10, 11, 0), 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, -1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 5));
    // flush together with a negative sample at idx 0
    vecs.push_back(vp(v(1, -5, 1, 1, 1, 0, -1), blk3(-5, 0, 0), 2));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 6));
    // flush while stalled: pending flush blocks input, second flush ignored
    vecs.push_back(v(1, 30, 0, 0, 1, 0, -1));
    vecs.push_back(v(1, 31, 0, 0, 1, 0, -1));
    vecs.push_back(vp(v(1, 32, 0, 0, 1, 0, -1), blk3(30, 31, 32), 0));
    vecs.push_back(v(1, 33, 0, 0, 1, 1, -1));
    vecs.push_back(vp(v(0, 0, 1, 0, 1, 1, -1), blk3(33, 0, 0), 2));
    vecs.push_back(v(1, 99, 1, 0, 0, 1, -1));
    vecs.push_back(v(1, 99, 0, 1, 0, 1, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, -1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 8));

    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b0;
    #3;
    chk_reset_state();
    @(negedge clk); reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i]);
    chk("sb_drained", sb.size(), 0);

    // async reset mid-block (idx = 2)
    step(v(1, 40, 0, 1, 1, 0, 8));
    step(v(1, 41, 0, 1, 1, 0, -1));
    @(negedge clk); s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_state();
    sb.delete();
    @(negedge clk); reset_n = 1'b1;

    // async reset mid-stall
    step(v(1, 60, 0, 0, 1, 0, 0));
    step(v(1, 61, 0, 0, 1, 0, -1));
    step(v(1, 62, 0, 0, 1, 0, -1));
    step(v(1, 63, 0, 0, 1, 1, -1));
    @(negedge clk); s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_state();
    sb.delete();
    @(negedge clk); reset_n = 1'b1;

    // restart from lane 0
    step(v(1, 50, 0, 1, 1, 0, 0));
    step(v(1, 51, 0, 1, 1, 0, -1));
    step(vp(v(1, 52, 0, 1, 1, 0, -1), blk3(50, 51, 52), 0));
    step(v(0, 0, 0, 1, 1, 1, -1));
    step(v(0, 0, 0, 1, 1, 0, 1));
    chk("sb_drained_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
